reg_desp_param: RTL



---
 rtl/reg_desp_param_pkg.sv | 23 ++
 rtl/reg_desp_step.sv | 41 ++++
 rtl/reg_desp_param.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/reg_desp_param_pkg.sv
// Shared encodings for the parametrised universal shift register.
package reg_desp_param_pkg;

  localparam logic [1:0] MODO_HOLD  = 2'b00;
  localparam logic [1:0] MODO_SHIFT = 2'b01;
  localparam logic [1:0] MODO_ROT   = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_e;

  // Only shift and rotate may start a multi-step operation.
  function automatic logic is_multi(logic [1:0] modo);
    return (modo == MODO_SHIFT) || (modo == MODO_ROT);
  endfunction

endpackage

// File: rtl/reg_desp_step.sv
// Combinational single step: next register value and outgoing bit for one
// hold/shift/rotate/load operation. Shared by the single-step and RUN paths.
module reg_desp_step
  import reg_desp_param_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic [1:0]       mode_i,
  input  logic             dir_i,
  input  logic             fill_i,
  input  logic             sout_i,
  output logic [WIDTH-1:0] q_o,
  output logic             sout_o
);

  logic out_bit;
  logic fill;

  // Decode the step; rotate feeds the outgoing bit back in as the fill.
  always_comb begin
    q_o     = q_i;
    sout_o  = sout_i;
    out_bit = (dir_i == DIR_LEFT) ? q_i[WIDTH-1] : q_i[0];
    fill    = (mode_i == MODO_ROT) ? out_bit : fill_i;
    case (mode_i)
      MODO_SHIFT, MODO_ROT: begin
        sout_o = out_bit;
        if (dir_i == DIR_LEFT) begin
          q_o = {q_i[WIDTH-2:0], fill};
        end else begin
          q_o = {fill, q_i[WIDTH-1:1]};
        end
      end
      MODO_LOAD: q_o = d_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/reg_desp_param.sv
// Parametrised universal shift register with a START/BUSY/DONE multi-step
// shift/rotate engine. Optional arithmetic right shift: REG_DESP_ARITH_EN.
module reg_desp_param
  import reg_desp_param_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ENB,
  input  logic             DIR,
  input  logic [1:0]       MODO,
  input  logic             S_IN,
  input  logic [WIDTH-1:0] D,
  input  logic             START,
  input  logic [CNT_W-1:0] AMT,
`ifdef REG_DESP_ARITH_EN
  input  logic             ARITH,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             S_OUT,
  output logic             BUSY,
  output logic             DONE
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic             dir_q, dir_d;
  logic             arith_q, arith_d;

  logic             arith_in;
  logic [1:0]       step_mode;
  logic             step_dir;
  logic             step_arith;
  logic             step_fill;
  logic [WIDTH-1:0] step_q;
  logic             step_sout;

`ifdef REG_DESP_ARITH_EN
  assign arith_in = ARITH;
`else
  assign arith_in = 1'b0;
`endif

  // Step operands: latched during RUN, live otherwise; arithmetic shift
  // replicates the sign bit.
  always_comb begin
    step_mode  = (state_q == StRun) ? mode_q  : MODO;
    step_dir   = (state_q == StRun) ? dir_q   : DIR;
    step_arith = (state_q == StRun) ? arith_q : arith_in;
    step_fill  = (step_arith && (step_mode == MODO_SHIFT) && (step_dir == DIR_RIGHT)) ?
                 q_q[WIDTH-1] : S_IN;
  end

  reg_desp_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .q_i    (q_q),
    .d_i    (D),
    .mode_i (step_mode),
    .dir_i  (step_dir),
    .fill_i (step_fill),
    .sout_i (sout_q),
    .q_o    (step_q),
    .sout_o (step_sout)
  );

  // Next-state logic for the FSM and datapath.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    sout_d  = sout_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    arith_d = arith_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (START && is_multi(MODO)) begin
          mode_d  = MODO;
          dir_d   = DIR;
          arith_d = arith_in;
          rem_d   = AMT;
          if (AMT == '0) begin
            state_d = StFin;
            done_d  = 1'b1;
          end else begin
            state_d = StRun;
            busy_d  = 1'b1;
          end
        end else begin
          q_d    = step_q;
          sout_d = step_sout;
        end
      end
      StRun: begin
        q_d    = step_q;
        sout_d = step_sout;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = StFin;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State register; RST wins over ENB, ENB=0 freezes everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rem_q   <= '0;
      mode_q  <= MODO_HOLD;
      dir_q   <= DIR_LEFT;
      arith_q <= 1'b0;
    end else if (ENB) begin
      state_q <= state_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      arith_q <= arith_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = sout_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;

endmodule
